// File: rtl/fsm_pkg.sv
// Shared definitions for the sequence driver of the 2-input, 4-state Moore FSM.
// Target state codes, driver control states and the state-to-input mapping.
package fsm_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } fsm_state_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10,
    ST_DONE  = 2'b11
  } drv_state_t;

  localparam logic [1:0] XZ_IDLE = 2'b00;

  // The target FSM's next state is {x,z}, so commanding S means x=S[1], z=S[0].
  function automatic logic [1:0] state_to_xz(input logic [1:0] s);
    return {s[1], s[0]};
  endfunction

endpackage

// File: rtl/seq_fifo.sv
// Synchronous FIFO of DEPTH 2-bit target-state entries with occupancy count.
// Push while full and pop while empty are ignored.
module seq_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [1:0]       push_data,
  input  logic             pop,
  output logic [1:0]       pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [1:0]       mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop against occupancy.
  always_comb begin
    do_push_s = push && (count_r != CNT_FULL);
    do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
  end

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign full     = (count_r == CNT_FULL);
  assign empty    = (count_r == {CNT_W{1'b0}});
  assign count    = count_r;

endmodule

// File: rtl/fsm_seq_driver.sv
// Replays a buffered sequence of target states onto the FSM's x/z inputs and
// flags every step where the observed FSM state differs from the commanded one.
module fsm_seq_driver
  import fsm_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [1:0]       load_state,
  output logic             load_ready,
  input  logic             start,
  output logic             x,
  output logic             z,
  input  logic [1:0]       obs_state,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  drv_state_t       state_r;
  logic             x_r;
  logic             z_r;
  logic             drive_v_r;
  logic             busy_r;
  logic             done_r;
  logic             load_ready_r;
  logic             exp_v_r;
  logic [1:0]       exp_q_r;
  logic             mismatch_r;
  logic [ERR_W-1:0] err_count_r;

  logic             push_s;
  logic             pop_s;
  logic             start_run_s;
  logic             full_s;
  logic             empty_s;
  logic [1:0]       head_s;
  logic [CNT_W-1:0] count_s;
  logic [CNT_W-1:0] cnt_nxt_s;

  seq_fifo #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_s),
    .push_data(load_state),
    .pop      (pop_s),
    .pop_data (head_s),
    .full     (full_s),
    .empty    (empty_s),
    .count    (count_s)
  );

  // Handshake and pop decode; cnt_nxt_s lets load_ready be registered yet exact.
  always_comb begin
    push_s      = load_valid && load_ready_r && !full_s;
    start_run_s = (state_r == ST_IDLE) && start && !empty_s;
    if (state_r == ST_RUN) begin
      pop_s = !empty_s;
    end else begin
      pop_s = start_run_s;
    end
    cnt_nxt_s = count_s + CNT_W'(push_s) - CNT_W'(pop_s);
  end

  // Control FSM with registered drive and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      x_r          <= 1'b0;
      z_r          <= 1'b0;
      drive_v_r    <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      load_ready_r <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start_run_s) begin
            state_r      <= ST_RUN;
            {x_r, z_r}   <= state_to_xz(head_s);
            drive_v_r    <= 1'b1;
            busy_r       <= 1'b1;
            load_ready_r <= 1'b0;
          end else begin
            {x_r, z_r}   <= XZ_IDLE;
            drive_v_r    <= 1'b0;
            busy_r       <= 1'b0;
            load_ready_r <= (cnt_nxt_s != CNT_FULL);
          end
        end
        ST_RUN: begin
          busy_r       <= 1'b1;
          done_r       <= 1'b0;
          load_ready_r <= 1'b0;
          if (!empty_s) begin
            {x_r, z_r} <= state_to_xz(head_s);
            drive_v_r  <= 1'b1;
          end else begin
            {x_r, z_r} <= XZ_IDLE;
            drive_v_r  <= 1'b0;
            state_r    <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          state_r      <= ST_DONE;
          {x_r, z_r}   <= XZ_IDLE;
          drive_v_r    <= 1'b0;
          busy_r       <= 1'b0;
          done_r       <= 1'b1;
          load_ready_r <= 1'b0;
        end
        ST_DONE: begin
          state_r      <= ST_IDLE;
          {x_r, z_r}   <= XZ_IDLE;
          drive_v_r    <= 1'b0;
          busy_r       <= 1'b0;
          done_r       <= 1'b0;
          load_ready_r <= (cnt_nxt_s != CNT_FULL);
        end
        default: begin
          state_r      <= ST_IDLE;
          {x_r, z_r}   <= XZ_IDLE;
          drive_v_r    <= 1'b0;
          busy_r       <= 1'b0;
          done_r       <= 1'b0;
          load_ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Checker pipeline: the FSM lands one edge after x/z, so compare one cycle late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q_r     <= 2'b00;
      exp_v_r     <= 1'b0;
      mismatch_r  <= 1'b0;
      err_count_r <= {ERR_W{1'b0}};
    end else begin
      exp_q_r    <= {x_r, z_r};
      exp_v_r    <= drive_v_r;
      mismatch_r <= exp_v_r && (obs_state != exp_q_r);
      if (start_run_s) begin
        err_count_r <= {ERR_W{1'b0}};
      end else if (exp_v_r && (obs_state != exp_q_r) && (err_count_r != ERR_MAX)) begin
        err_count_r <= err_count_r + ERR_W'(1);
      end else begin
        err_count_r <= err_count_r;
      end
    end
  end

  assign x          = x_r;
  assign z          = z_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign load_ready = load_ready_r;
  assign mismatch   = mismatch_r;
  assign err_count  = err_count_r;

endmodule

// File: tb/tb_fsm_seq_driver.sv
// Directed bench for fsm_seq_driver: loopback to a modelled FSM, fault injection,
// full buffer, empty start, mid-run reset and error-counter saturation.
module tb_fsm_seq_driver;
  import fsm_pkg::*;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic [1:0] load_state;
  logic       load_ready;
  logic       start;
  logic       x;
  logic       z;
  logic [1:0] obs_state;
  logic       busy;
  logic       done;
  logic       mismatch;
  logic [7:0] err_count;

  logic       load_valid2;
  logic [1:0] load_state2;
  logic       load_ready2;
  logic       start2;
  logic       x2;
  logic       z2;
  logic       busy2;
  logic       done2;
  logic       mismatch2;
  logic [1:0] err_count2;

  logic [1:0] fsm_q;
  logic       obs_tied;
  logic [1:0] xz;

  int total;
  int bad;

  fsm_seq_driver #(.DEPTH(8), .ERR_W(8)) u_dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_state(load_state),
    .load_ready(load_ready), .start(start), .x(x), .z(z), .obs_state(obs_state),
    .busy(busy), .done(done), .mismatch(mismatch), .err_count(err_count)
  );

  fsm_seq_driver #(.DEPTH(8), .ERR_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .load_valid(load_valid2), .load_state(load_state2),
    .load_ready(load_ready2), .start(start2), .x(x2), .z(z2), .obs_state(2'b00),
    .busy(busy2), .done(done2), .mismatch(mismatch2), .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference 4-state Moore FSM: next state is {x,z}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= 2'b00;
    else     fsm_q <= {x, z};
  end

  assign obs_state = obs_tied ? 2'b00 : fsm_q;
  assign xz        = {x, z};

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load1(input logic [1:0] s);
    load_valid = 1'b1;
    load_state = s;
    tick();
    load_valid = 1'b0;
  endtask

  logic [1:0] seq1 [4];
  logic [1:0] seq3 [9];
  int         pulses;

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; load_valid = 1'b0; load_state = 2'b00; start = 1'b0; obs_tied = 1'b0;
    load_valid2 = 1'b0; load_state2 = 2'b00; start2 = 1'b0;
    seq1[0] = S1; seq1[1] = S3; seq1[2] = S2; seq1[3] = S0;
    seq3[0] = S1; seq3[1] = S2; seq3[2] = S3; seq3[3] = S1; seq3[4] = S2;
    seq3[5] = S3; seq3[6] = S1; seq3[7] = S2; seq3[8] = S3;

    tick(); tick();
    chk_eq("rst_xz", 32'(xz), 32'd0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_done", 32'(done), 32'd0);
    chk_eq("rst_mm", 32'(mismatch), 32'd0);
    chk_eq("rst_err", 32'(err_count), 32'd0);
    rst = 1'b0;
    tick();
    chk_eq("rst_ready", 32'(load_ready), 32'd1);

    // Loopback: S1,S3,S2,S0
    for (int i = 0; i < 4; i++) load1(seq1[i]);
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk_eq("lb_xz", 32'(xz), 32'(seq1[k]));
      chk_eq("lb_busy", 32'(busy), 32'd1);
      chk_eq("lb_mm", 32'(mismatch), 32'd0);
      chk_eq("lb_ready", 32'(load_ready), 32'd0);
      tick();
    end
    chk_eq("lb_flush_xz", 32'(xz), 32'd0);
    chk_eq("lb_flush_busy", 32'(busy), 32'd1);
    chk_eq("lb_flush_done", 32'(done), 32'd0);
    chk_eq("lb_flush_mm", 32'(mismatch), 32'd0);
    tick();
    chk_eq("lb_done", 32'(done), 32'd1);
    chk_eq("lb_done_busy", 32'(busy), 32'd0);
    chk_eq("lb_done_mm", 32'(mismatch), 32'd0);
    chk_eq("lb_err", 32'(err_count), 32'd0);
    tick();
    chk_eq("lb_after_done", 32'(done), 32'd0);
    chk_eq("lb_after_ready", 32'(load_ready), 32'd1);

    // Fault injection: obs tied to S0, sequence S2,S0,S3
    obs_tied = 1'b1;
    load1(S2); load1(S0); load1(S3);
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk_eq($sformatf("fi_mm_c%0d", c), 32'(mismatch), ((c == 3) || (c == 5)) ? 32'd1 : 32'd0);
      if (c == 1) chk_eq("fi_xz1", 32'(xz), 32'(S2));
      if (c == 3) chk_eq("fi_xz3", 32'(xz), 32'(S3));
      if (c == 5) begin
        chk_eq("fi_done", 32'(done), 32'd1);
        chk_eq("fi_err", 32'(err_count), 32'd2);
      end
      tick();
    end
    obs_tied = 1'b0;

    // Full buffer: nine back-to-back offers, eight accepted
    load_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      load_state = seq3[i];
      chk_eq($sformatf("full_ready_%0d", i), 32'(load_ready), (i < 8) ? 32'd1 : 32'd0);
      tick();
    end
    load_valid = 1'b0;
    chk_eq("full_ready_hold", 32'(load_ready), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk_eq($sformatf("full_xz_%0d", k), 32'(xz), 32'(seq3[k]));
      tick();
    end
    chk_eq("full_xz_end", 32'(xz), 32'd0);
    chk_eq("full_busy_flush", 32'(busy), 32'd1);
    tick();
    chk_eq("full_done", 32'(done), 32'd1);
    chk_eq("full_err", 32'(err_count), 32'd0);
    tick();

    // Start with an empty buffer
    start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_eq("empty_busy", 32'(busy), 32'd0);
      chk_eq("empty_done", 32'(done), 32'd0);
      chk_eq("empty_xz", 32'(xz), 32'd0);
    end
    start = 1'b0;

    // Reset mid-run; tied obs so err_count is nonzero before the reset
    obs_tied = 1'b1;
    load1(S1); load1(S2); load1(S3); load1(S1); load1(S2); load1(S3);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk_eq("mr_err_pre", 32'(err_count), 32'd1);
    chk_eq("mr_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk_eq("mr_xz", 32'(xz), 32'd0);
    chk_eq("mr_busy", 32'(busy), 32'd0);
    chk_eq("mr_err", 32'(err_count), 32'd0);
    tick();
    rst = 1'b0;
    obs_tied = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk_eq("mr_no_done", 32'(done), 32'd0);
      chk_eq("mr_ready", 32'(load_ready), 32'd1);
    end
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk_eq("mr_restart_busy", 32'(busy), 32'd0);
      chk_eq("mr_restart_done", 32'(done), 32'd0);
      tick();
    end

    // Saturation with ERR_W=2: six S3 steps against obs=S0
    load_valid2 = 1'b1; load_state2 = S3;
    for (int i = 0; i < 6; i++) tick();
    load_valid2 = 1'b0;
    start2 = 1'b1; tick(); start2 = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 9; c++) begin
      if (mismatch2) pulses++;
      if (c == 4) chk_eq("sat_err_c4", 32'(err_count2), 32'd2);
      if (c == 5) chk_eq("sat_err_c5", 32'(err_count2), 32'd3);
      if (c == 8) begin
        chk_eq("sat_done", 32'(done2), 32'd1);
        chk_eq("sat_err_done", 32'(err_count2), 32'd3);
      end
      tick();
    end
    chk_eq("sat_pulses", 32'(pulses), 32'd6);
    chk_eq("sat_err_hold", 32'(err_count2), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
